// File: rtl/bayer_frame_gen.sv
// bayer_frame_gen: Bayer CFA test-frame source (ramp / flat CFA / checkerboard / constant), G_PIXELS pixels per beat.
// Latency: first beat valid one cycle after START_I is sampled; per-line HBLANK_I idle cycles, G_VBLANK idle cycles per frame.
// Backpressure: beat advances only on DATA_VALID_O & READY_I, DATA_O held while stalled; blanking ignores READY_I.
//
// Optional feature macro: BAYER_FRAME_GEN_CHECKSUM_EN builds a 32-bit per-frame sum of accepted pixels on CHECKSUM_O;
// without it CHECKSUM_O is tied to zero.
//
// Ports:
//   SYS_CLK_I, RESET_I (synchronous, active-high)
//   START_I (level), MODE_I, BAYER_FORMAT_I, H_RES_I, V_RES_I, HBLANK_I : frame configuration, latched at frame start
//   READY_I / DATA_VALID_O / DATA_O : pixel stream, lane p holds pixel x+p, lane 0 in the LSBs
//   EOF_O (one-cycle pulse on first VBLANK cycle), BUSY_O, FRAME_CNT_O, CHECKSUM_O
module bayer_frame_gen #(
    parameter int unsigned G_DATA_WIDTH = 8,
    parameter int unsigned G_PIXELS     = 1,
    parameter int unsigned G_RES_WIDTH  = 13,
    parameter int unsigned G_VBLANK     = 16,
    parameter logic [G_DATA_WIDTH-1:0] G_R_VAL = 8'hC0,
    parameter logic [G_DATA_WIDTH-1:0] G_G_VAL = 8'h80,
    parameter logic [G_DATA_WIDTH-1:0] G_B_VAL = 8'h40
) (
    input  logic                               SYS_CLK_I,
    input  logic                               RESET_I,
    input  logic                               START_I,
    input  logic [1:0]                         MODE_I,
    input  logic [1:0]                         BAYER_FORMAT_I,
    input  logic [G_RES_WIDTH-1:0]             H_RES_I,
    input  logic [G_RES_WIDTH-1:0]             V_RES_I,
    input  logic [G_RES_WIDTH-1:0]             HBLANK_I,
    input  logic                               READY_I,
    output logic [G_PIXELS*G_DATA_WIDTH-1:0]   DATA_O,
    output logic                               DATA_VALID_O,
    output logic                               EOF_O,
    output logic                               BUSY_O,
    output logic [15:0]                        FRAME_CNT_O,
    output logic [31:0]                        CHECKSUM_O
);

    // The blanking counter serves both HBLANK_I and G_VBLANK, so it must hold the larger of the two.
    localparam int unsigned VB_W = $clog2(G_VBLANK + 1);
    localparam int unsigned BW   = (G_RES_WIDTH > VB_W) ? G_RES_WIDTH : VB_W;
    localparam logic [G_RES_WIDTH-1:0] STEP    = G_RES_WIDTH'(G_PIXELS);
    localparam logic [G_RES_WIDTH-1:0] ONE     = G_RES_WIDTH'(1);
    localparam logic [BW-1:0]          VB_LAST = BW'(G_VBLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]             cfg_mode;
    logic [1:0]             cfg_fmt;
    logic [G_RES_WIDTH-1:0] cfg_h;
    logic [G_RES_WIDTH-1:0] cfg_v;
    logic [G_RES_WIDTH-1:0] cfg_hb;

    logic [G_RES_WIDTH-1:0] x;
    logic [G_RES_WIDTH-1:0] y;
    logic [BW-1:0]          blank_cnt;
    logic [15:0]            frame_cnt;

    logic start_ok;
    logic load_cfg;
    logic beat_acc;
    logic line_end;
    logic frame_end;
    logic hb_last;
    logic vb_last;

    logic [G_PIXELS*G_DATA_WIDTH-1:0] pix_bus;

    // A zero-sized frame request is ignored rather than producing an empty frame.
    assign start_ok  = START_I && (H_RES_I != '0) && (V_RES_I != '0);
    assign beat_acc  = (state == S_ACTIVE) && READY_I;
    assign line_end  = (x == cfg_h - STEP);
    assign frame_end = line_end && (y == cfg_v - ONE);
    assign hb_last   = (blank_cnt == BW'(cfg_hb - ONE));
    assign vb_last   = (blank_cnt == VB_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge SYS_CLK_I) begin
        if (RESET_I) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_cfg     = 1'b0;
        DATA_VALID_O = 1'b0;
        EOF_O        = 1'b0;
        BUSY_O       = 1'b1;
        case (state)
            S_IDLE: begin
                BUSY_O = 1'b0;
                if (start_ok) begin
                    state_nxt = S_ACTIVE;
                    load_cfg  = 1'b1;
                end
            end
            S_ACTIVE: begin
                DATA_VALID_O = 1'b1;
                if (beat_acc && line_end) begin
                    if (frame_end) begin
                        state_nxt = S_VBLANK;
                    end else if (cfg_hb != '0) begin
                        state_nxt = S_HBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (hb_last) begin
                    state_nxt = S_ACTIVE;
                end
            end
            S_VBLANK: begin
                EOF_O = (blank_cnt == '0);
                if (vb_last) begin
                    if (start_ok) begin
                        state_nxt = S_ACTIVE;
                        load_cfg  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration, position and blanking counters
    // ------------------------------------------------------------------
    always_ff @(posedge SYS_CLK_I) begin
        if (RESET_I) begin
            cfg_mode  <= '0;
            cfg_fmt   <= '0;
            cfg_h     <= '0;
            cfg_v     <= '0;
            cfg_hb    <= '0;
            x         <= '0;
            y         <= '0;
            blank_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if (load_cfg) begin
                cfg_mode <= MODE_I;
                cfg_fmt  <= BAYER_FORMAT_I;
                cfg_h    <= H_RES_I;
                cfg_v    <= V_RES_I;
                cfg_hb   <= HBLANK_I;
                x        <= '0;
                y        <= '0;
            end else if (beat_acc) begin
                if (line_end) begin
                    x <= '0;
                    y <= y + ONE;
                end else begin
                    x <= x + STEP;
                end
            end

            // Counts cycles spent in the current blanking interval; restarts on any state change.
            if ((state == S_HBLANK || state == S_VBLANK) && state_nxt == state) begin
                blank_cnt <= blank_cnt + BW'(1);
            end else begin
                blank_cnt <= '0;
            end

            // Incremented on the edge entering VBLANK so the new count is visible alongside EOF_O.
            if (beat_acc && frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign FRAME_CNT_O = frame_cnt;

    // ------------------------------------------------------------------
    // Pixel generation
    // ------------------------------------------------------------------
    function automatic logic [G_DATA_WIDTH-1:0] pixel_value(
        input logic [G_RES_WIDTH-1:0] px,
        input logic [G_RES_WIDTH-1:0] py,
        input logic [1:0]             mode,
        input logic [1:0]             fmt
    );
        logic [1:0]           site;
        logic [G_RES_WIDTH:0] sum;
        // Site code 0 is R, 3 is B, 1/2 are G; the format acts as an XOR phase on the 2x2 tile.
        site = {py[0], px[0]} ^ fmt;
        sum  = {1'b0, px} + {1'b0, py};
        pixel_value = '0;
        case (mode)
            2'd0: pixel_value = G_DATA_WIDTH'(sum);
            2'd1: begin
                case (site)
                    2'd0:    pixel_value = G_R_VAL;
                    2'd3:    pixel_value = G_B_VAL;
                    default: pixel_value = G_G_VAL;
                endcase
            end
            2'd2:    pixel_value = (px[3] ^ py[3]) ? '1 : '0;
            default: pixel_value = G_G_VAL;
        endcase
        return pixel_value;
    endfunction

    for (genvar p = 0; p < int'(G_PIXELS); p++) begin : g_lane
        assign pix_bus[p*G_DATA_WIDTH +: G_DATA_WIDTH] =
            pixel_value(x + G_RES_WIDTH'(p), y, cfg_mode, cfg_fmt);
    end

    // Output is forced to zero outside active beats so idle/blanking cycles show a clean bus.
    assign DATA_O = DATA_VALID_O ? pix_bus : '0;

    // ------------------------------------------------------------------
    // Optional per-frame checksum
    // ------------------------------------------------------------------
`ifdef BAYER_FRAME_GEN_CHECKSUM_EN
    logic [31:0] beat_sum;
    logic [31:0] acc;
    logic [31:0] checksum;

    always_comb begin
        beat_sum = '0;
        for (int p = 0; p < int'(G_PIXELS); p++) begin
            beat_sum = beat_sum + 32'(pix_bus[p*G_DATA_WIDTH +: G_DATA_WIDTH]);
        end
    end

    always_ff @(posedge SYS_CLK_I) begin
        if (RESET_I) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            if (load_cfg) begin
                acc <= '0;
            end else if (beat_acc) begin
                acc <= acc + beat_sum;
            end
            // The final beat is folded in directly so the result lands on the EOF_O cycle.
            if (beat_acc && frame_end) begin
                checksum <= acc + beat_sum;
            end
        end
    end

    assign CHECKSUM_O = checksum;
`else
    assign CHECKSUM_O = '0;
`endif

endmodule

// File: tb/tb_bayer_frame_gen.sv
// tb_bayer_frame_gen: randomized self-checking bench for bayer_frame_gen with a 2-pixel-per-beat instance.
// Latency: n/a (testbench).
// Backpressure: READY_I driven always-high, alternating or random per scenario.
module tb_bayer_frame_gen;

    localparam int PIX = 2;
    localparam int DW  = 8;
    localparam int RW  = 13;
    localparam int VB  = 5;
    localparam int BUS = PIX * DW;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     mode;
    logic [1:0]     fmt;
    logic [RW-1:0]  h_res;
    logic [RW-1:0]  v_res;
    logic [RW-1:0]  hblank;
    logic           ready;
    logic [BUS-1:0] data;
    logic           valid;
    logic           eof;
    logic           busy;
    logic [15:0]    fcnt;
    logic [31:0]    csum;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_fcnt = 0;

    // Captured observations of the last capture() call.
    logic [BUS-1:0] got_dat[$];
    int             got_cyc[$];
    int             eof_cyc[$];
    logic [15:0]    eof_fcnt[$];
    logic [31:0]    eof_sum[$];
    int             stall_bad;
    bit             end_busy;

    bayer_frame_gen #(
        .G_DATA_WIDTH(DW),
        .G_PIXELS    (PIX),
        .G_RES_WIDTH (RW),
        .G_VBLANK    (VB)
    ) dut (
        .SYS_CLK_I     (clk),
        .RESET_I       (rst),
        .START_I       (start),
        .MODE_I        (mode),
        .BAYER_FORMAT_I(fmt),
        .H_RES_I       (h_res),
        .V_RES_I       (v_res),
        .HBLANK_I      (hblank),
        .READY_I       (ready),
        .DATA_O        (data),
        .DATA_VALID_O  (valid),
        .EOF_O         (eof),
        .BUSY_O        (busy),
        .FRAME_CNT_O   (fcnt),
        .CHECKSUM_O    (csum)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: pixel rules straight from the pattern definitions
    // ------------------------------------------------------------------
    function automatic logic [7:0] ref_pix(input int m, input int f, input int x, input int y);
        string cfa;
        byte   c;
        case (f)
            0:       cfa = "RGGB";
            1:       cfa = "GRBG";
            2:       cfa = "GBRG";
            default: cfa = "BGGR";
        endcase
        c = cfa[(y % 2) * 2 + (x % 2)];
        case (m)
            0:       return 8'((x + y) % 256);
            1:       return (c == "R") ? 8'hC0 : (c == "B") ? 8'h40 : 8'h80;
            2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [BUS-1:0] ref_beat(input int m, input int f, input int h, input int k);
        logic [BUS-1:0] r;
        int bpl;
        bpl = h / PIX;
        r = '0;
        for (int p = 0; p < PIX; p++)
            r[p*DW +: DW] = ref_pix(m, f, (k % bpl) * PIX + p, k / bpl);
        return r;
    endfunction

    function automatic logic [31:0] ref_sum(input int m, input int f, input int h, input int v);
        logic [31:0] s;
        s = '0;
`ifdef BAYER_FRAME_GEN_CHECKSUM_EN
        for (int yy = 0; yy < v; yy++)
            for (int xx = 0; xx < h; xx++)
                s = s + 32'(ref_pix(m, f, xx, yy));
`else
        if (m + f + h + v < 0) s = 32'd1;
`endif
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus/capture engine (no checking). Cycle 0 is the first falling
    // edge after the rising edge that samples START.
    // rdy_mode: 0 always ready, 1 alternating 1010..., 2 random.
    // ------------------------------------------------------------------
    task automatic capture(input int max_cyc, input int want_eof, input int tail,
                           input int rdy_mode, input bit hold_start, input bit scramble);
        logic [BUS-1:0] pdat;
        bit             pstall;
        int             left;
        got_dat.delete(); got_cyc.delete(); eof_cyc.delete(); eof_fcnt.delete(); eof_sum.delete();
        stall_bad = 0;
        pstall = 1'b0;
        pdat = '0;
        left = -1;
        end_busy = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (scramble) begin
                mode   = 2'($urandom);
                fmt    = 2'($urandom);
                h_res  = RW'($urandom_range(0, 64));
                v_res  = RW'($urandom_range(0, 64));
                hblank = RW'($urandom_range(0, 9));
            end
            case (rdy_mode)
                0:       ready = 1'b1;
                1:       ready = (c % 2 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (pstall && data !== pdat) stall_bad++;
            if (valid && ready) begin
                got_dat.push_back(data);
                got_cyc.push_back(c);
            end
            pstall = valid && !ready;
            pdat = data;
            if (eof) begin
                eof_cyc.push_back(c);
                eof_fcnt.push_back(fcnt);
                eof_sum.push_back(csum);
                if (eof_cyc.size() == want_eof) left = tail + 1;
            end
            end_busy = busy;
            if (left > 0) begin
                left--;
                if (left == 0) break;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] act[6];
        string       nm[6];
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        mode = '0; fmt = '0; h_res = '0; v_res = '0; hblank = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        act[0] = 32'(valid); nm[0] = "reset_valid";
        act[1] = 32'(eof);   nm[1] = "reset_eof";
        act[2] = 32'(busy);  nm[2] = "reset_busy";
        act[3] = 32'(fcnt);  nm[3] = "reset_frame_cnt";
        act[4] = csum;       nm[4] = "reset_checksum";
        act[5] = 32'(data);  nm[5] = "reset_data";
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (act[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL %s: got %0h expected 0", nm[i], act[i]);
            end
        end
        exp_fcnt = 0;
    endtask

    // 8x4 ramp, HBLANK=2, always ready, inputs scrambled mid-frame.
    task automatic test_ramp();
        int m = 0, f = 0, h = 8, v = 4, hb = 2, bpl = 4, nb = 16;
        mode = 2'(m); fmt = 2'(f); h_res = RW'(h); v_res = RW'(v); hblank = RW'(hb); start = 1'b1;
        capture(400, 1, VB, 0, 1'b0, 1'b1);
        n_cmp++;
        if (got_dat.size() != nb) begin
            n_bad++; $display("FAIL ramp_beats: got %0d expected %0d", got_dat.size(), nb);
        end
        for (int k = 0; k < nb && k < got_dat.size(); k++) begin
            n_cmp++;
            if (got_dat[k] !== ref_beat(m, f, h, k)) begin
                n_bad++; $display("FAIL ramp_data[%0d]: got %h expected %h", k, got_dat[k], ref_beat(m, f, h, k));
            end
            n_cmp++;
            if (got_cyc[k] != (k / bpl) * (bpl + hb) + k % bpl) begin
                n_bad++; $display("FAIL ramp_timing[%0d]: got cycle %0d expected %0d", k, got_cyc[k], (k / bpl) * (bpl + hb) + k % bpl);
            end
        end
        n_cmp++;
        if (eof_cyc.size() != 1) begin
            n_bad++; $display("FAIL ramp_eof_count: got %0d expected 1", eof_cyc.size());
        end else begin
            exp_fcnt++;
            n_cmp++;
            if (eof_cyc[0] != (v - 1) * (bpl + hb) + bpl) begin
                n_bad++; $display("FAIL ramp_eof_cycle: got %0d expected %0d", eof_cyc[0], (v - 1) * (bpl + hb) + bpl);
            end
            n_cmp++;
            if (eof_fcnt[0] !== 16'(exp_fcnt)) begin
                n_bad++; $display("FAIL ramp_frame_cnt: got %0d expected %0d", eof_fcnt[0], exp_fcnt);
            end
            n_cmp++;
            if (eof_sum[0] !== ref_sum(m, f, h, v)) begin
                n_bad++; $display("FAIL ramp_checksum: got %0d expected %0d", eof_sum[0], ref_sum(m, f, h, v));
            end
        end
        n_cmp++;
        if (end_busy !== 1'b0) begin
            n_bad++; $display("FAIL ramp_idle_after_vblank: busy %0b expected 0", end_busy);
        end
        n_cmp++;
        if (csum !== ref_sum(m, f, h, v)) begin
            n_bad++; $display("FAIL ramp_checksum_hold: got %0d expected %0d", csum, ref_sum(m, f, h, v));
        end
    endtask

    // 4x2 flat CFA, RGGB and BGGR, against literal site values.
    task automatic test_flat_cfa();
        logic [BUS-1:0] exp_tab[2][4];
        exp_tab[0] = '{16'h80C0, 16'h80C0, 16'h4080, 16'h4080};
        exp_tab[1] = '{16'h8040, 16'h8040, 16'hC080, 16'hC080};
        for (int i = 0; i < 2; i++) begin
            mode = 2'd1; fmt = (i == 0) ? 2'd0 : 2'd3; h_res = RW'(4); v_res = RW'(2);
            hblank = RW'($urandom_range(0, 3)); start = 1'b1;
            capture(200, 1, 0, 2, 1'b0, 1'b0);
            n_cmp++;
            if (got_dat.size() != 4) begin
                n_bad++; $display("FAIL flat_beats[%0d]: got %0d expected 4", i, got_dat.size());
            end
            for (int k = 0; k < 4 && k < got_dat.size(); k++) begin
                n_cmp++;
                if (got_dat[k] !== exp_tab[i][k]) begin
                    n_bad++; $display("FAIL flat_data[%0d][%0d]: got %h expected %h", i, k, got_dat[k], exp_tab[i][k]);
                end
            end
            if (eof_cyc.size() == 1) exp_fcnt++;
        end
    endtask

    // 8x2 ramp with READY toggling 1010...: no loss, no duplication, data held while stalled.
    task automatic test_backpressure();
        mode = 2'd0; fmt = 2'd0; h_res = RW'(8); v_res = RW'(2); hblank = RW'($urandom_range(0, 3)); start = 1'b1;
        capture(200, 1, 0, 1, 1'b0, 1'b0);
        n_cmp++;
        if (got_dat.size() != 8) begin
            n_bad++; $display("FAIL bp_beats: got %0d expected 8", got_dat.size());
        end
        n_cmp++;
        if (got_dat.size() < 1 || got_dat[0] !== 16'h0100) begin
            n_bad++; $display("FAIL bp_beat0: got %h expected 0100", (got_dat.size() > 0) ? got_dat[0] : 16'hxxxx);
        end
        n_cmp++;
        if (got_dat.size() < 8 || got_dat[7] !== 16'h0807) begin
            n_bad++; $display("FAIL bp_beat7: got %h expected 0807", (got_dat.size() > 7) ? got_dat[7] : 16'hxxxx);
        end
        for (int k = 1; k < 7 && k < got_dat.size(); k++) begin
            n_cmp++;
            if (got_dat[k] !== ref_beat(0, 0, 8, k)) begin
                n_bad++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got_dat[k], ref_beat(0, 0, 8, k));
            end
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++; $display("FAIL bp_stall_hold: %0d changes while stalled, expected 0", stall_bad);
        end
        if (eof_cyc.size() == 1) exp_fcnt++;
    endtask

    // Random sizes, patterns, formats, blanking and READY.
    task automatic test_random_frames();
        for (int t = 0; t < 16; t++) begin
            int m, f, h, v, hb, nb;
            m = $urandom_range(0, 3); f = $urandom_range(0, 3);
            h = PIX * $urandom_range(1, 12); v = $urandom_range(1, 20); hb = $urandom_range(0, 4);
            nb = (h / PIX) * v;
            mode = 2'(m); fmt = 2'(f); h_res = RW'(h); v_res = RW'(v); hblank = RW'(hb); start = 1'b1;
            capture(4000, 1, 0, 2, 1'b0, 1'b1);
            n_cmp++;
            if (got_dat.size() != nb || eof_cyc.size() != 1) begin
                n_bad++; $display("FAIL rnd_count[%0d]: got %0d beats %0d eof expected %0d beats 1 eof", t, got_dat.size(), eof_cyc.size(), nb);
            end
            for (int k = 0; k < nb && k < got_dat.size(); k++) begin
                n_cmp++;
                if (got_dat[k] !== ref_beat(m, f, h, k)) begin
                    n_bad++; $display("FAIL rnd_data[%0d][%0d]: got %h expected %h (m%0d f%0d %0dx%0d)", t, k, got_dat[k], ref_beat(m, f, h, k), m, f, h, v);
                end
            end
            n_cmp++;
            if (stall_bad != 0) begin
                n_bad++; $display("FAIL rnd_stall_hold[%0d]: %0d changes while stalled, expected 0", t, stall_bad);
            end
            if (eof_cyc.size() == 1) begin
                exp_fcnt++;
                n_cmp++;
                if (eof_sum[0] !== ref_sum(m, f, h, v) || eof_fcnt[0] !== 16'(exp_fcnt)) begin
                    n_bad++; $display("FAIL rnd_eof[%0d]: sum %0d cnt %0d expected sum %0d cnt %0d", t, eof_sum[0], eof_fcnt[0], ref_sum(m, f, h, v), exp_fcnt);
                end
            end
        end
    endtask

    // START held: two 4x2 frames separated by exactly VB idle cycles.
    task automatic test_back_to_back();
        int m = 0, f = 1, h = 4, v = 2, bpf = 4;
        mode = 2'(m); fmt = 2'(f); h_res = RW'(h); v_res = RW'(v); hblank = '0; start = 1'b1;
        capture(300, 2, 0, 0, 1'b1, 1'b0);
        n_cmp++;
        if (eof_cyc.size() != 2 || got_dat.size() != 2 * bpf) begin
            n_bad++; $display("FAIL b2b_count: got %0d eof %0d beats expected 2 eof %0d beats", eof_cyc.size(), got_dat.size(), 2 * bpf);
        end else begin
            for (int k = 0; k < 2 * bpf; k++) begin
                n_cmp++;
                if (got_dat[k] !== ref_beat(m, f, h, k % bpf)) begin
                    n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, got_dat[k], ref_beat(m, f, h, k % bpf));
                end
                if (k < bpf) begin
                    n_cmp++;
                    if (got_cyc[k] != k) begin
                        n_bad++; $display("FAIL b2b_no_hblank[%0d]: got cycle %0d expected %0d", k, got_cyc[k], k);
                    end
                end
            end
            n_cmp++;
            if (got_cyc[bpf] - eof_cyc[0] != VB) begin
                n_bad++; $display("FAIL b2b_vblank_gap: got %0d idle cycles expected %0d", got_cyc[bpf] - eof_cyc[0], VB);
            end
            exp_fcnt += 2;
            n_cmp++;
            if (eof_fcnt[1] !== 16'(exp_fcnt)) begin
                n_bad++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", eof_fcnt[1], exp_fcnt);
            end
        end
    endtask

    // Reset in the middle of line 1, then zero-sized start requests.
    task automatic test_reset_midframe();
        int  acc = 0, eofs = 0, busys = 0;
        bit  hit = 1'b0;
        mode = 2'd0; fmt = 2'd0; h_res = RW'(8); v_res = RW'(4); hblank = RW'(1); ready = 1'b1; start = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid && ready) acc++;
            if (acc == 6) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL rst_mid_reach: got %0d beats expected 6 before timeout", acc);
        end
        @(negedge clk);
        n_cmp++;
        if ({valid, busy, eof} !== 3'b000 || fcnt !== 16'd0 || data !== '0) begin
            n_bad++; $display("FAIL rst_mid_outputs: valid %0b busy %0b eof %0b cnt %0d data %h expected all 0", valid, busy, eof, fcnt, data);
        end
        rst = 1'b0;
        exp_fcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (eof) eofs++;
            if (busy) busys++;
        end
        n_cmp++;
        if (eofs != 0 || busys != 0) begin
            n_bad++; $display("FAIL rst_mid_quiet: got %0d eof %0d busy cycles expected 0 0", eofs, busys);
        end
        busys = 0;
        start = 1'b1; h_res = RW'(8); v_res = '0;
        repeat (5) begin @(negedge clk); if (busy || valid) busys++; end
        h_res = '0; v_res = RW'(4);
        repeat (5) begin @(negedge clk); if (busy || valid) busys++; end
        start = 1'b0;
        n_cmp++;
        if (busys != 0) begin
            n_bad++; $display("FAIL zero_size_start: got %0d busy cycles expected 0", busys);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        mode = '0; fmt = '0; h_res = '0; v_res = '0; hblank = '0;
        test_reset();
        test_ramp();
        test_flat_cfa();
        test_backpressure();
        test_random_frames();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
